route_table_writer: RTL and testbench

- Write-side companion to the routing-table lookup mux.
- Owns the flat routing-table vector that the lookup mux reads: ENTRIES entries of PORT_W bits each.
- Programs single entries over a valid/ready handshake.
- Supports a bulk clear that sequentially fills every entry with a default output port.
- Sits in each router next to the route-lookup mux and is driven by the NoC configuration master.

---
 rtl/route_table_writer.sv | 142 ++++++++++++++
 tb/tb_route_table_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/route_table_writer.sv
// Write side of the routing table: single-entry programming over valid/ready
// plus a sequential bulk clear. Define ROUTE_TBL_VERIFY_EN for read-back verify.
`ifndef LOG_PORTS_CNT
`define LOG_PORTS_CNT 3
`endif

module route_table_writer #(
  parameter int unsigned       ENTRIES = 1000,
  parameter int unsigned       PORT_W  = `LOG_PORTS_CNT,
  parameter int unsigned       ADDR_W  = 10,
  parameter logic [PORT_W-1:0] CLR_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [PORT_W-1:0]          wr_port,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [0:ENTRIES*PORT_W-1]  TABLE
);

  localparam int unsigned       IDX_W     = $clog2(ENTRIES * PORT_W);
  localparam logic [ADDR_W:0]   ENTRIES_X = (ADDR_W + 1)'(ENTRIES);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
`ifdef ROUTE_TBL_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [PORT_W-1:0]         port_q, port_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [0:ENTRIES*PORT_W-1] table_q;

  logic                      addr_ok;
  logic                      tbl_we;
  logic [ADDR_W-1:0]         tbl_idx;
  logic [PORT_W-1:0]         tbl_val;
  logic [IDX_W-1:0]          wr_base;

  assign addr_ok = ({1'b0, addr_q} < ENTRIES_X);
  // Base bit offset is only meaningful when the index is in range; tbl_we guards it.
  assign wr_base = IDX_W'(tbl_idx * PORT_W);

`ifdef ROUTE_TBL_VERIFY_EN
  logic [IDX_W-1:0]  rd_base;
  logic [PORT_W-1:0] rd_port;
  assign rd_base = IDX_W'(addr_q * PORT_W);
  assign rd_port = addr_ok ? table_q[rd_base +: PORT_W] : '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    port_d  = port_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tbl_we  = 1'b0;
    tbl_idx = addr_q;
    tbl_val = port_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (wr_valid) begin
          state_d = WRITE;
          addr_d  = wr_addr;
          port_d  = wr_port;
        end
      end
      WRITE: begin
        tbl_we = addr_ok;
`ifdef ROUTE_TBL_VERIFY_EN
        state_d = VERIFY;
`else
        done_d  = 1'b1;
        err_d   = !addr_ok;
        state_d = IDLE;
`endif
      end
`ifdef ROUTE_TBL_VERIFY_EN
      VERIFY: begin
        done_d  = 1'b1;
        err_d   = !addr_ok || (rd_port != port_q);
        state_d = IDLE;
      end
`endif
      CLEAR: begin
        tbl_we  = 1'b1;
        tbl_idx = cnt_q;
        tbl_val = CLR_VAL;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      port_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      table_q <= {ENTRIES{CLR_VAL}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      port_q  <= port_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (tbl_we) table_q[wr_base +: PORT_W] <= tbl_val;
    end
  end

  assign wr_ready = (state_q == IDLE) && !clr_req;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign TABLE    = table_q;

endmodule

// File: tb/tb_route_table_writer.sv
// Directed bench for route_table_writer: writes, address boundaries, back-to-back
// writes, bulk clear, clear/write priority and reset during clear.
module tb_route_table_writer;

  localparam int ENTRIES = 1000;
  localparam int PW      = 3;
  localparam int AW      = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [PW-1:0]     wr_port;
  logic              clr_req;
  logic              busy;
  logic              done;
  logic              err;
  logic [0:ENTRIES*PW-1] tbl;

  logic [PW-1:0] m [ENTRIES];
  logic [PW-1:0] bbp [1:4] = '{3'd6, 3'd1, 3'd2, 3'd5};

  int n_assert = 0;
  int n_fail   = 0;

  route_table_writer #(
    .ENTRIES(ENTRIES),
    .PORT_W (PW),
    .ADDR_W (AW),
    .CLR_VAL(3'd0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_port (wr_port),
    .clr_req (clr_req),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .TABLE   (tbl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_table(input string tag);
    int bad;
    int first;
    bad   = 0;
    first = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tbl[i*PW +: PW] !== m[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    n_assert++;
    assert (bad == 0)
    else begin
      n_fail++;
      $error("FAIL %s: %0d entries differ, first entry %0d observed %0h expected %0h",
             tag, bad, first, tbl[first*PW +: PW], m[first]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m[i] = 3'd0;
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a, input logic [PW-1:0] p,
                          input logic exp_err);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_port  = p;
    chk({tag, "/ready_idle"}, 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk({tag, "/busy"}, 32'(busy), 32'd1);
    chk({tag, "/ready_wr"}, 32'(wr_ready), 32'd0);
    chk({tag, "/done_early"}, 32'(done), 32'd0);
`ifdef ROUTE_TBL_VERIFY_EN
    tick();
    chk({tag, "/done_verify"}, 32'(done), 32'd0);
    chk({tag, "/busy_verify"}, 32'(busy), 32'd1);
`endif
    tick();
    chk({tag, "/done"}, 32'(done), 32'd1);
    chk({tag, "/err"}, 32'(err), 32'(exp_err));
    chk({tag, "/busy_end"}, 32'(busy), 32'd0);
    if (!exp_err) m[a] = p;
    chk_table(tag);
    tick();
    chk({tag, "/done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "/err_1cyc"}, 32'(err), 32'd0);
  endtask

  // Called one sample after the clear was entered; returns at the sample where done pulses.
  task automatic wait_clear(input string tag);
    int busy_cnt;
    int done_cnt;
    int viol;
    busy_cnt = 0;
    done_cnt = 0;
    viol     = 0;
    for (int i = 0; i < 1100; i++) begin
      if (done) done_cnt++;
      if (!busy) break;
      busy_cnt++;
      if (wr_ready) viol++;
      tick();
    end
    chk({tag, "/busy_cycles"}, 32'(busy_cnt), 32'd1000);
    chk({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "/ready_during"}, 32'(viol), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_port  = '0;
    clr_req  = 1'b0;
    model_clear();

    #1 rst_n = 1'b0;
    #1;
    chk("rst/ready", 32'(wr_ready), 32'd1);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/err", 32'(err), 32'd0);
    chk_table("rst/table");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_write("w5", 10'd5, 3'd3, 1'b0);
    chk("w5/slice", 32'(tbl[15:17]), 32'd3);

    do_write("w999", 10'd999, 3'd7, 1'b0);
    do_write("w1000", 10'd1000, 3'd2, 1'b1);
    do_write("w1023", 10'd1023, 3'd1, 1'b1);

    wr_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wr_addr = 10'(k);
      wr_port = bbp[k];
      chk("b2b/ready_idle", 32'(wr_ready), 32'd1);
      tick();
      chk("b2b/ready_wr", 32'(wr_ready), 32'd0);
      chk("b2b/busy", 32'(busy), 32'd1);
`ifdef ROUTE_TBL_VERIFY_EN
      tick();
      chk("b2b/ready_verify", 32'(wr_ready), 32'd0);
`endif
      tick();
      chk("b2b/done", 32'(done), 32'd1);
      m[k] = bbp[k];
    end
    wr_valid = 1'b0;
    chk_table("b2b/table");
    tick();

    clr_req = 1'b1;
    #1;
    chk("clr/ready_req", 32'(wr_ready), 32'd0);
    tick();
    clr_req  = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 10'd10;
    wr_port  = 3'd5;
    wait_clear("clr");
    wr_valid = 1'b0;
    model_clear();
    chk_table("clr/table");
    tick();
    chk("clr/no_accept", 32'(busy), 32'd0);
    chk("clr/done_1cyc", 32'(done), 32'd0);

    do_write("w20", 10'd20, 3'd7, 1'b0);
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 10'd30;
    wr_port  = 3'd4;
    #1;
    chk("prio/ready", 32'(wr_ready), 32'd0);
    tick();
    clr_req = 1'b0;
    wait_clear("prio");
    chk("prio/ready_after", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("prio/accepted", 32'(busy), 32'd1);
`ifdef ROUTE_TBL_VERIFY_EN
    tick();
`endif
    tick();
    chk("prio/done", 32'(done), 32'd1);
    chk("prio/err", 32'(err), 32'd0);
    model_clear();
    m[30] = 3'd4;
    chk_table("prio/table");
    tick();

    do_write("w900", 10'd900, 3'd5, 1'b0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (500) tick();
    chk("rstclr/busy_before", 32'(busy), 32'd1);
    chk("rstclr/e900_before", 32'(tbl[2700:2702]), 32'd5);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rstclr/busy", 32'(busy), 32'd0);
    chk("rstclr/done", 32'(done), 32'd0);
    chk("rstclr/err", 32'(err), 32'd0);
    chk("rstclr/ready", 32'(wr_ready), 32'd1);
    chk_table("rstclr/table");
    tick();
    chk("rstclr/done_held", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstclr/done_after", 32'(done), 32'd0);
    chk("rstclr/busy_after", 32'(busy), 32'd0);

    do_write("w7", 10'd7, 3'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
